// File: rtl/irrigation_pkg.sv
// Shared types and default timing for the irrigation actuator sequencer.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef enum logic {
    SEL_ASP = 1'b0,
    SEL_GOT = 1'b1
  } line_sel_t;

  typedef struct packed {
    logic inlet_valve;
    logic pump_en;
    logic asp_valve;
    logic got_valve;
    logic alarm;
  } act_out_t;

  localparam int unsigned DEF_MIN_ON  = 4;
  localparam int unsigned DEF_MIN_OFF = 2;
  localparam int unsigned DEF_CLEAR   = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// One-bit two-flop synchronizer with async active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irrigation_actuator_seq.sv
// Tick-paced pump/valve sequencer for sprinkler and drip lines, with fault lockout
// and an independent tank-refill valve.
module irrigation_actuator_seq
  import irrigation_pkg::*;
#(
  parameter int unsigned MIN_ON  = DEF_MIN_ON,
  parameter int unsigned MIN_OFF = DEF_MIN_OFF,
  parameter int unsigned CLEAR   = DEF_CLEAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       error,
  input  logic       watter_supply,
  input  logic       asp,
  input  logic       got,
  output logic       inlet_valve,
  output logic       pump_en,
  output logic       asp_valve,
  output logic       got_valve,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = max3(MIN_ON, MIN_OFF, CLEAR);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MIN_ON  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_MIN_OFF = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] CNT_CLEAR   = CNT_W'(CLEAR);

  logic error_s, watter_supply_s, asp_s, got_s;

  sync2 u_sync_error (.clk(clk), .rst_n(rst_n), .d(error),         .q(error_s));
  sync2 u_sync_ws    (.clk(clk), .rst_n(rst_n), .d(watter_supply), .q(watter_supply_s));
  sync2 u_sync_asp   (.clk(clk), .rst_n(rst_n), .d(asp),           .q(asp_s));
  sync2 u_sync_got   (.clk(clk), .rst_n(rst_n), .d(got),           .q(got_s));

  state_t           state_q, state_d;
  line_sel_t        sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  act_out_t         out_q, out_d;

  // State, line select, shared counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ASP;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next state and next outputs; outputs are decoded from the state being entered.
  always_comb begin
    logic             req_sel;
    logic             valve_on;
    logic [CNT_W-1:0] cnt_inc;

    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    out_d    = '0;
    req_sel  = (sel_q == SEL_ASP) ? asp_s : got_s;
    cnt_inc  = cnt_q + CNT_W'(1);
    valve_on = 1'b0;

    if (error_s) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (asp_s) begin
            sel_d   = SEL_ASP;
            state_d = ST_OPEN;
          end else if (got_s) begin
            sel_d   = SEL_GOT;
            state_d = ST_OPEN;
          end
        end
        ST_OPEN: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_RUN: begin
          // A drip run yields to a sprinkler request once minimum run time is met.
          if ((cnt_q >= CNT_MIN_ON) && (!req_sel || ((sel_q == SEL_GOT) && asp_s))) begin
            state_d = ST_STOP;
          end else if (cnt_q < CNT_MIN_ON) begin
            cnt_d = cnt_inc;
          end
        end
        ST_STOP: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_inc == CNT_MIN_OFF) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_FAULT: begin
          if (cnt_inc == CNT_CLEAR) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    valve_on          = (state_d == ST_OPEN) || (state_d == ST_RUN) || (state_d == ST_STOP);
    out_d.asp_valve   = valve_on && (sel_d == SEL_ASP);
    out_d.got_valve   = valve_on && (sel_d == SEL_GOT);
    out_d.pump_en     = (state_d == ST_RUN);
    out_d.inlet_valve = watter_supply_s && (state_d != ST_FAULT);
    out_d.alarm       = (state_d == ST_FAULT) &&
                        (out_q.alarm ^ ((state_q == ST_FAULT) && tick));
  end

  assign inlet_valve = out_q.inlet_valve;
  assign pump_en     = out_q.pump_en;
  assign asp_valve   = out_q.asp_valve;
  assign got_valve   = out_q.got_valve;
  assign alarm       = out_q.alarm;
  assign state       = state_q;

endmodule
